// File: rtl/delay_line_prober.sv
// Delay-line latency prober: drives a marker word into a line and counts edges until it returns.
// Optional marker-width check (CHECK state, width_err) is built when DELAY_PROBE_WIDTH_CHECK_EN is defined.
module delay_line_prober #(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] PATTERN   = 8'hA5,
    parameter int                MAX_DELAY = 127,
    parameter int                CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] echo_in,
    output logic [DATA_W-1:0] probe_out,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  delay,
    output logic              width_err
);
    localparam logic [DATA_W-1:0] IDLE_WORD = ~PATTERN;
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_DELAY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_SEND,
        S_WAIT,
`ifdef DELAY_PROBE_WIDTH_CHECK_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] probe_q, probe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  delay_q, delay_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              hit;
`ifdef DELAY_PROBE_WIDTH_CHECK_EN
    logic              werr_q, werr_d;
`endif

    always_comb begin
        state_d   = state_q;
        probe_d   = IDLE_WORD;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        delay_d   = delay_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        hit       = 1'b0;
`ifdef DELAY_PROBE_WIDTH_CHECK_EN
        werr_d    = werr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FLUSH;
                    busy_d    = 1'b1;
                    timeout_d = 1'b0;
                    flush_d   = '0;
`ifdef DELAY_PROBE_WIDTH_CHECK_EN
                    werr_d    = 1'b0;
`endif
                end
            end
            S_FLUSH: begin
                // probe_out is registered, so PATTERN is loaded on the edge that enters SEND
                if (flush_q == MAX_CNT) begin
                    state_d = S_SEND;
                    probe_d = PATTERN;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            S_SEND: begin
                if (echo_in == PATTERN) begin
                    cnt_d = '0;
                    hit   = 1'b1;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (echo_in == PATTERN) begin
                    hit = 1'b1;
                end else if (cnt_q == MAX_CNT) begin
                    state_d   = S_DONE;
                    delay_d   = '1;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef DELAY_PROBE_WIDTH_CHECK_EN
            S_CHECK: begin
                // A correctly sized marker is gone one cycle after it arrives
                werr_d  = (echo_in != IDLE_WORD);
                delay_d = cnt_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (hit) begin
`ifdef DELAY_PROBE_WIDTH_CHECK_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
            delay_d = cnt_d;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            probe_q   <= IDLE_WORD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            delay_q   <= '0;
            cnt_q     <= '0;
            flush_q   <= '0;
`ifdef DELAY_PROBE_WIDTH_CHECK_EN
            werr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            probe_q   <= probe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            delay_q   <= delay_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
`ifdef DELAY_PROBE_WIDTH_CHECK_EN
            werr_q    <= werr_d;
`endif
        end
    end

    assign probe_out = probe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign delay     = delay_q;
`ifdef DELAY_PROBE_WIDTH_CHECK_EN
    assign width_err = werr_q;
`else
    assign width_err = 1'b0;
`endif

endmodule

// File: tb/tb_delay_line_prober.sv
// Bench for delay_line_prober: two instances (MAX_DELAY 127 and 60), each with a modelled delay line.
module tb_delay_line_prober;
    localparam logic [7:0] PAT = 8'hA5;
`ifdef DELAY_PROBE_WIDTH_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    typedef struct {
        int         dut;
        int         n;
        logic       st;
        int         dl;
        logic [7:0] dm;
        logic [7:0] exp_d;
        logic       exp_to;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start;
    logic [7:0]  echo [2];
    wire  [15:0] probe_w;
    wire  [15:0] dly_w;
    wire  [1:0]  busy, done, tmo, werr;

    int          len [2];
    logic        stretch [2];
    int          dlen [2];
    logic [7:0]  dmask [2];
    logic [255:0] mk [2];
    logic        clr;
    logic [7:0]  last_d [2];
    int          checks = 0;
    int          failures = 0;
    vec_t        tbl [12];

    always #5 clk = ~clk;

    delay_line_prober #(.DATA_W(8), .PATTERN(8'hA5), .MAX_DELAY(127), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .echo_in(echo[0]),
        .probe_out(probe_w[7:0]), .busy(busy[0]), .done(done[0]), .timeout(tmo[0]),
        .delay(dly_w[7:0]), .width_err(werr[0])
    );

    delay_line_prober #(.DATA_W(8), .PATTERN(8'hA5), .MAX_DELAY(60), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .echo_in(echo[1]),
        .probe_out(probe_w[15:8]), .busy(busy[1]), .done(done[1]), .timeout(tmo[1]),
        .delay(dly_w[15:8]), .width_err(werr[1])
    );

    // Line model: mk[k] is 1 where the marker entered the line k+1 edges ago
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            mk[i] <= clr ? '0 : {mk[i][254:0], probe_w[8*i +: 8] == PAT};
    end

    function automatic logic [7:0] echo_f(input logic [7:0] p, input logic [255:0] m, input int l,
                                          input logic st, input int dl, input logic [7:0] dm);
        logic arr;
        arr = (l == 0) ? (p == PAT) : m[l-1];
        if (st && m[l]) arr = 1'b1;
        if (arr) return PAT;
        if (dl > 0 && m[dl-1]) return PAT ^ dm;
        return ~PAT;
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++)
            echo[i] = echo_f(probe_w[8*i +: 8], mk[i], len[i], stretch[i], dlen[i], dmask[i]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic setup_line(input int i, input int n, input logic st, input int dl, input logic [7:0] dm);
        len[i] = n; stretch[i] = st; dlen[i] = dl; dmask[i] = dm;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, inout int cyc);
        while (done[i] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // One full measurement; expected latency follows from the phase lengths FLUSH=MAX+1, SEND=1, WAIT=n
    task automatic measure(input int i, input int n, input logic st, input int dl, input logic [7:0] dm,
                           input logic [7:0] exp_d, input logic exp_to, input int poke);
        int maxd, lat, cyc;
        logic bad_busy, bad_probe, exp_w;
        maxd  = (i == 0) ? 127 : 60;
        exp_w = (CHK == 1) && st && !exp_to;
        lat   = exp_to ? 2*maxd + 3 : maxd + 3 + n + CHK;
        setup_line(i, n, st, dl, dm);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        cyc = 1;
        chk($sformatf("busy_after_start d%0d", i), busy[i], 1);
        chk($sformatf("timeout_cleared d%0d", i), tmo[i], 0);
        chk($sformatf("werr_cleared d%0d", i), werr[i], 0);
        bad_busy = 1'b0; bad_probe = 1'b0;
        while (done[i] !== 1'b1 && cyc < lat + 20) begin
            if (busy[i] !== 1'b1) bad_busy = 1'b1;
            if (probe_w[8*i +: 8] !== ((cyc == maxd + 2) ? PAT : ~PAT)) bad_probe = 1'b1;
            @(negedge clk);
            cyc++;
            start[i] = (poke != 0 && cyc == poke);
        end
        start[i] = 1'b0;
        chk($sformatf("latency d%0d n=%0d", i, n), cyc, lat);
        chk($sformatf("done d%0d n=%0d", i, n), done[i], 1);
        chk($sformatf("delay d%0d n=%0d", i, n), dly_w[8*i +: 8], exp_d);
        chk($sformatf("timeout d%0d n=%0d", i, n), tmo[i], exp_to);
        chk($sformatf("width_err d%0d n=%0d", i, n), werr[i], exp_w);
        chk($sformatf("busy_at_done d%0d", i), busy[i], 0);
        chk($sformatf("busy_seq d%0d n=%0d", i, n), bad_busy, 0);
        chk($sformatf("probe_seq d%0d n=%0d", i, n), bad_probe, 0);
        @(negedge clk);
        chk($sformatf("done_one_cycle d%0d", i), done[i], 0);
        chk($sformatf("delay_held d%0d", i), dly_w[8*i +: 8], exp_d);
        chk($sformatf("timeout_sticky d%0d", i), tmo[i], exp_to);
        last_d[i] = exp_d;
    endtask

    initial begin
        int cyc, n, dl;
        logic st, to;
        logic [7:0] dm, ed;

        tbl[0]  = '{0,  30, 1'b0,  0, 8'h00, 8'd30,  1'b0};
        tbl[1]  = '{0,   0, 1'b0,  0, 8'h00, 8'd0,   1'b0};
        tbl[2]  = '{0,   1, 1'b0,  0, 8'h00, 8'd1,   1'b0};
        tbl[3]  = '{0, 127, 1'b0,  0, 8'h00, 8'd127, 1'b0};
        tbl[4]  = '{0, 128, 1'b0,  0, 8'h00, 8'hFF,  1'b1};
        tbl[5]  = '{0,  20, 1'b0, 10, 8'h01, 8'd20,  1'b0};
        tbl[6]  = '{0,  50, 1'b0, 49, 8'h80, 8'd50,  1'b0};
        tbl[7]  = '{0,  25, 1'b1,  0, 8'h00, 8'd25,  1'b0};
        tbl[8]  = '{0,   0, 1'b1,  0, 8'h00, 8'd0,   1'b0};
        tbl[9]  = '{1,  60, 1'b0,  0, 8'h00, 8'd60,  1'b0};
        tbl[10] = '{1,  61, 1'b0,  0, 8'h00, 8'hFF,  1'b1};
        tbl[11] = '{1,  90, 1'b0,  0, 8'h00, 8'hFF,  1'b1};

        start = 2'b00; clr = 1'b1; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            len[i] = 0; stretch[i] = 1'b0; dlen[i] = 0; dmask[i] = 8'h00; last_d[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0; clr = 1'b0;
        @(negedge clk);
        chk("reset probe d0", probe_w[7:0], 8'h5A);
        chk("reset probe d1", probe_w[15:8], 8'h5A);
        chk("reset busy", busy, 2'b00);
        chk("reset done", done, 2'b00);
        chk("reset timeout", tmo, 2'b00);
        chk("reset delay", dly_w, 16'h0000);
        chk("reset width_err", werr, 2'b00);

        for (int k = 0; k < 12; k++)
            measure(tbl[k].dut, tbl[k].n, tbl[k].st, tbl[k].dl, tbl[k].dm, tbl[k].exp_d, tbl[k].exp_to, 0);

        // start pulsed in the middle of WAIT must not disturb the measurement
        measure(0, 45, 1'b0, 0, 8'h00, 8'd45, 1'b0, 127 + 3 + 20);

        // asynchronous reset mid-WAIT; dut1 still holds its timeout result
        setup_line(0, 45, 1'b0, 0, 8'h00);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (149) @(negedge clk);
        chk("midwait busy", busy[0], 1);
        chk("midwait delay held", dly_w[7:0], last_d[0]);
        chk("pre-reset timeout d1", tmo[1], 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst probe", probe_w[7:0], 8'h5A);
        chk("async rst busy", busy, 2'b00);
        chk("async rst done", done, 2'b00);
        chk("async rst timeout", tmo, 2'b00);
        chk("async rst delay", dly_w, 16'h0000);
        chk("async rst width_err", werr, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        measure(0, 45, 1'b0, 0, 8'h00, 8'd45, 1'b0, 0);

        // start held high across DONE restarts from IDLE one cycle later
        setup_line(0, 5, 1'b0, 0, 8'h00);
        start[0] = 1'b1;
        @(negedge clk);
        cyc = 1;
        wait_done(0, 200, cyc);
        chk("held first latency", cyc, 127 + 3 + 5 + CHK);
        chk("held first delay", dly_w[7:0], 8'd5);
        @(negedge clk);
        chk("held idle busy", busy[0], 0);
        chk("held idle done", done[0], 0);
        @(negedge clk);
        chk("held restart busy", busy[0], 1);
        start[0] = 1'b0;
        cyc = 1;
        wait_done(0, 200, cyc);
        chk("held second latency", cyc, 127 + 3 + 5 + CHK);
        chk("held second delay", dly_w[7:0], 8'd5);
        @(negedge clk);

        // randomized lines: delay is the line length, or all-ones once it exceeds MAX_DELAY
        for (int r = 0; r < 16; r++) begin
            n  = $urandom_range(0, 135);
            st = 1'($urandom_range(0, 1));
            dl = (n > 1) ? $urandom_range(0, n - 1) : 0;
            dm = 8'($urandom_range(1, 255));
            to = (n > 127);
            ed = to ? 8'hFF : 8'(n);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            measure(0, n, st, dl, dm, ed, to, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
